// File: rtl/iq_sched_pkg.sv
// Shared types and constants for the I/Q pairing scheduler.
package iq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  localparam int COUNT_WIDTH        = 32;
  localparam int DEFAULT_SKEW_LIMIT = 16;

endpackage

// File: rtl/iq_skew_monitor.sv
// Counts consecutive cycles where only one of the I/Q FIFOs holds data and
// raises a sticky error once the run length reaches SKEW_LIMIT.
module iq_skew_monitor
  import iq_sched_pkg::*;
#(
  parameter int SKEW_LIMIT = DEFAULT_SKEW_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic I_empty,
  input  logic Q_empty,
  output logic skew_err
);

  localparam int CW = $clog2(SKEW_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          one_sided;

  assign one_sided = I_empty ^ Q_empty;

  // Counter saturates at SKEW_LIMIT so a long imbalance cannot wrap it.
  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (one_sided) begin
      cnt_d = (int'(cnt_q) >= SKEW_LIMIT) ? cnt_q : cnt_q + 1'b1;
      if (int'(cnt_q) + 1 >= SKEW_LIMIT) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign skew_err = err_q;

endmodule

// File: rtl/iq_pair_sched.sv
// Lockstep I/Q FIFO popper with keep-1-of-N decimation and a valid/ready output
// register. Skew monitor is built only when IQ_SCHED_SKEW_CHECK_EN is defined.
module iq_pair_sched
  import iq_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DECIM_WIDTH = 8,
  parameter int SKEW_LIMIT  = DEFAULT_SKEW_LIMIT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic                   I_empty,
  input  logic [DATA_WIDTH-1:0]  I_dout,
  output logic                   I_rd_en,
  input  logic                   Q_empty,
  input  logic [DATA_WIDTH-1:0]  Q_dout,
  output logic                   Q_rd_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_I,
  output logic [DATA_WIDTH-1:0]  out_Q,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   skew_err
);

  sched_state_e            state_q, state_d;
  logic [DECIM_WIDTH-1:0]  n_q, n_d;
  logic [DECIM_WIDTH-1:0]  phase_q, phase_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   i_q, i_d, q_q, q_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    pop, keep, handoff;

  assign handoff = valid_q & out_ready;
  assign pop     = (state_q == RUN) & ~I_empty & ~Q_empty & (~valid_q | out_ready);
  assign keep    = pop & (phase_q == '0);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          n_d     = (decim == '0) ? DECIM_WIDTH'(1) : decim;
          phase_d = '0;
        end
      end
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN:   if (!valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // pop only occurs in RUN, so this never collides with the IDLE clear.
    if (pop) begin
      phase_d = (phase_q >= n_q - 1'b1) ? '0 : phase_q + 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    i_d     = i_q;
    q_d     = q_q;
    if (keep) begin
      valid_d = 1'b1;
      i_d     = I_dout;
      q_d     = Q_dout;
    end else if (handoff) begin
      valid_d = 1'b0;
    end
    count_d = count_q + COUNT_WIDTH'(handoff);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= DECIM_WIDTH'(1);
      phase_q <= '0;
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      i_q     <= i_d;
      q_q     <= q_d;
      count_q <= count_d;
    end
  end

  assign I_rd_en   = pop;
  assign Q_rd_en   = pop;
  assign out_valid = valid_q;
  assign out_I     = i_q;
  assign out_Q     = q_q;
  assign out_count = count_q;

`ifdef IQ_SCHED_SKEW_CHECK_EN
  iq_skew_monitor #(
    .SKEW_LIMIT(SKEW_LIMIT)
  ) u_skew_monitor (
    .clock   (clock),
    .reset   (reset),
    .I_empty (I_empty),
    .Q_empty (Q_empty),
    .skew_err(skew_err)
  );
`else
  logic unused_skew_limit;
  assign unused_skew_limit = (SKEW_LIMIT != 0);
  assign skew_err          = 1'b0;
`endif

endmodule
